// File: rtl/cafeteria_pkg.sv
// Shared constants for the cafeteria range front end: value widths, range
// limit, the ASCII characters the parser recognises and the parser states.
package cafeteria_pkg;

    localparam int WIDTH     = 50;
    localparam int NUM_RANGE = 182;
    localparam int CNT_W     = 10;

    localparam logic [7:0] ASCII_0    = 8'h30;
    localparam logic [7:0] ASCII_9    = 8'h39;
    localparam logic [7:0] ASCII_DASH = 8'h2D;
    localparam logic [7:0] ASCII_LF   = 8'h0A;
    localparam logic [7:0] ASCII_CR   = 8'h0D;

    typedef enum logic [2:0] {
        S_IDLE,
        S_P_START,
        S_P_END,
        S_EMIT,
        S_DONE,
        S_ERR
    } parse_state_e;

    function automatic logic is_digit(input logic [7:0] b);
        return (b >= ASCII_0) && (b <= ASCII_9);
    endfunction

endpackage

// File: rtl/dec_accum.sv
// Decimal accumulator: holds a W-bit value, offers value*10+digit together
// with an overflow flag, and commits that result when digit_en is high.
module dec_accum #(
    parameter int W = 50
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         digit_en,
    input  logic [3:0]   digit,
    output logic [W-1:0] value,
    output logic         ovf
);

    logic [W-1:0] acc_q;
    logic [W+3:0] prod;

    // Four guard bits are enough for acc*10+9, so any set guard bit means overflow
    always_comb begin
        prod = ({4'd0, acc_q} * (W+4)'(10)) + {{W{1'b0}}, digit};
        ovf  = |prod[W+3:W];
    end

    // Accumulator register; clear has priority over a new digit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
        end else if (clr) begin
            acc_q <= '0;
        end else if (digit_en) begin
            acc_q <= prod[W-1:0];
        end
    end

    assign value = acc_q;

endmodule

// File: rtl/range_list_parser.sv
// Streaming "a-b\n" range list parser: turns ASCII bytes into (start,end)
// integer pairs over a valid/ready handshake, stopping at a blank line, at
// in_last, or after MAX_RANGES ranges.
// Optional feature macro RANGE_PARSER_SWAP_EN: emit inverted ranges swapped
// so that rng_start <= rng_end always holds.
module range_list_parser #(
    parameter int WIDTH      = cafeteria_pkg::WIDTH,
    parameter int MAX_RANGES = cafeteria_pkg::NUM_RANGE,
    parameter int CNT_W      = cafeteria_pkg::CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_data,
    input  logic             in_last,
    output logic             rng_valid,
    input  logic             rng_ready,
    output logic [WIDTH-1:0] rng_start,
    output logic [WIDTH-1:0] rng_end,
    output logic [CNT_W-1:0] range_count,
    output logic             done,
    output logic             err
);

    import cafeteria_pkg::*;

    parse_state_e     state_q, state_d;
    logic             seen_q, seen_d;
    logic             last_q, last_d;
    logic [WIDTH-1:0] rng_start_q, rng_start_d;
    logic [WIDTH-1:0] rng_end_q, rng_end_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic             take;
    logic             byte_digit;
    logic [3:0]       digit_val;
    logic             clr_acc, s_en, e_en;
    logic [WIDTH-1:0] acc_s, acc_e;
    logic             ovf_s, ovf_e;

    assign in_ready   = (state_q == S_P_START) || (state_q == S_P_END);
    assign take       = in_valid && in_ready;
    assign byte_digit = is_digit(in_data);
    // ASCII digits are 0x30..0x39, so the low nibble already is the digit value
    assign digit_val  = in_data[3:0];

    dec_accum #(.W(WIDTH)) u_acc_start (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr_acc),
        .digit_en (s_en),
        .digit    (digit_val),
        .value    (acc_s),
        .ovf      (ovf_s)
    );

    dec_accum #(.W(WIDTH)) u_acc_end (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr_acc),
        .digit_en (e_en),
        .digit    (digit_val),
        .value    (acc_e),
        .ovf      (ovf_e)
    );

    // Next-state logic: byte classification per field, emit handshake, restart
    always_comb begin
        state_d     = state_q;
        seen_d      = seen_q;
        last_d      = last_q;
        rng_start_d = rng_start_q;
        rng_end_d   = rng_end_q;
        count_d     = count_q;
        clr_acc     = 1'b0;
        s_en        = 1'b0;
        e_en        = 1'b0;
        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_d = S_P_START;
                    seen_d  = 1'b0;
                    last_d  = 1'b0;
                    count_d = '0;
                    clr_acc = 1'b1;
                end
            end
            S_P_START: begin
                if (take) begin
                    if (byte_digit) begin
                        if (ovf_s || in_last) begin
                            state_d = S_ERR;
                        end else begin
                            s_en   = 1'b1;
                            seen_d = 1'b1;
                        end
                    end else if (in_data == ASCII_CR) begin
                        if (in_last) state_d = S_ERR;
                    end else if (in_data == ASCII_DASH && seen_q && !in_last) begin
                        state_d = S_P_END;
                        seen_d  = 1'b0;
                    end else if (in_data == ASCII_LF && !seen_q) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_ERR;
                    end
                end
            end
            S_P_END: begin
                if (take) begin
                    if (byte_digit) begin
                        if (ovf_e || in_last) begin
                            state_d = S_ERR;
                        end else begin
                            e_en   = 1'b1;
                            seen_d = 1'b1;
                        end
                    end else if (in_data == ASCII_CR) begin
                        if (in_last) state_d = S_ERR;
                    end else if (in_data == ASCII_LF && seen_q) begin
                        state_d = S_EMIT;
                        last_d  = in_last;
`ifdef RANGE_PARSER_SWAP_EN
                        if (acc_s > acc_e) begin
                            rng_start_d = acc_e;
                            rng_end_d   = acc_s;
                        end else begin
                            rng_start_d = acc_s;
                            rng_end_d   = acc_e;
                        end
`else
                        rng_start_d = acc_s;
                        rng_end_d   = acc_e;
`endif
                    end else begin
                        state_d = S_ERR;
                    end
                end
            end
            S_EMIT: begin
                if (rng_ready) begin
                    count_d = count_q + CNT_W'(1);
                    clr_acc = 1'b1;
                    seen_d  = 1'b0;
                    if ((count_q + CNT_W'(1)) == CNT_W'(MAX_RANGES) || last_q) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_P_START;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers; reset aborts any parse in progress
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            seen_q      <= 1'b0;
            last_q      <= 1'b0;
            rng_start_q <= '0;
            rng_end_q   <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            seen_q      <= seen_d;
            last_q      <= last_d;
            rng_start_q <= rng_start_d;
            rng_end_q   <= rng_end_d;
            count_q     <= count_d;
        end
    end

    assign rng_valid   = (state_q == S_EMIT);
    assign rng_start   = rng_start_q;
    assign rng_end     = rng_end_q;
    assign range_count = count_q;
    assign done        = (state_q == S_DONE) || (state_q == S_ERR);
    assign err         = (state_q == S_ERR);

endmodule

// File: tb/tb_range_list_parser.sv
// Testbench for range_list_parser: directed and random byte streams checked
// against a string-level reference parser kept in the bench.
module tb_range_list_parser;

    localparam longint unsigned MAXV = (64'd1 << 50) - 64'd1;
    localparam int MAXR = 182;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_last = 1'b0;
    logic        rng_ready = 1'b0;
    logic        in_ready;
    logic        rng_valid;
    logic [49:0] rng_start;
    logic [49:0] rng_end;
    logic [9:0]  range_count;
    logic        done;
    logic        err;

    int vecCnt = 0;
    int errCnt = 0;

    logic [7:0]      stim[$];
    longint unsigned expS[$];
    longint unsigned expE[$];
    bit              expErr;
    int              expConsumed;

    range_list_parser dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_last     (in_last),
        .rng_valid   (rng_valid),
        .rng_ready   (rng_ready),
        .rng_start   (rng_start),
        .rng_end     (rng_end),
        .range_count (range_count),
        .done        (done),
        .err         (err)
    );

    // Free-running clock
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vecCnt++;
        if (got !== exp) begin
            errCnt++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic addText(input string s);
        for (int i = 0; i < s.len(); i++) stim.push_back(s[i]);
    endtask

    task automatic addRange(input longint unsigned a, input longint unsigned b, input bit cr);
        addText($sformatf("%0d-%0d", a, b));
        if (cr) stim.push_back(8'h0D);
        stim.push_back(8'h0A);
    endtask

    function automatic longint unsigned randVal();
        int r;
        r = $urandom_range(0, 9);
        case (r)
            0, 1, 2: return longint'($urandom_range(0, 99));
            3, 4:    return longint'($urandom_range(0, 1000000));
            5, 6:    return {$urandom, $urandom} & MAXV;
            7:       return MAXV - longint'($urandom_range(0, 3));
            8:       return 64'd0;
            default: return MAXV + 64'd1 + longint'($urandom_range(0, 1000));
        endcase
    endfunction

    // Reference parser: walks the byte string line by line using the
    // character rules directly, producing the expected ranges and outcome
    task automatic buildModel();
        longint unsigned acc[2];
        longint unsigned v, a, b;
        bit seen;
        int fld;
        bit isLast;
        logic [7:0] c;
        expS.delete();
        expE.delete();
        expErr = 1'b0;
        expConsumed = 0;
        acc = '{64'd0, 64'd0};
        seen = 1'b0;
        fld = 0;
        for (int i = 0; i < stim.size(); i++) begin
            c = stim[i];
            isLast = (i == stim.size() - 1);
            expConsumed = i + 1;
            if (c >= 8'h30 && c <= 8'h39) begin
                v = acc[fld] * 64'd10 + longint'(c - 8'h30);
                if (v > MAXV || isLast) begin
                    expErr = 1'b1;
                    return;
                end
                acc[fld] = v;
                seen = 1'b1;
            end else if (c == 8'h0D) begin
                if (isLast) begin
                    expErr = 1'b1;
                    return;
                end
            end else if (c == 8'h2D && fld == 0 && seen && !isLast) begin
                fld = 1;
                seen = 1'b0;
            end else if (c == 8'h0A && fld == 0 && !seen) begin
                return;
            end else if (c == 8'h0A && fld == 1 && seen) begin
                a = acc[0];
                b = acc[1];
`ifdef RANGE_PARSER_SWAP_EN
                if (a > b) begin
                    a = acc[1];
                    b = acc[0];
                end
`endif
                expS.push_back(a);
                expE.push_back(b);
                if (expS.size() == MAXR || isLast) return;
                acc = '{64'd0, 64'd0};
                fld = 0;
                seen = 1'b0;
            end else begin
                expErr = 1'b1;
                return;
            end
        end
    endtask

    // Runs one parse of stim; readyMode 0 = full rate, 1 = random, 2 = stall first emit 5 cycles
    task automatic applyStimulus(input string tag, input int readyMode);
        int idx, emitIdx, cyc, lastEvt, stall, budget;
        bit fin;
        buildModel();
        @(negedge clk);
        start = 1'b1;
        in_valid = 1'b0;
        rng_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        idx = 0;
        emitIdx = 0;
        cyc = 0;
        lastEvt = 0;
        stall = 0;
        fin = 1'b0;
        budget = stim.size() * 12 + 100;
        while (!fin) begin
            if (done) begin
                fin = 1'b1;
            end else if (cyc > budget) begin
                checkOutput({tag, ".doneTimeout"}, done, 1);
                fin = 1'b1;
            end else begin
                if (rng_valid) begin
                    checkOutput({tag, ".inReadyEmit"}, in_ready, 0);
                    checkOutput({tag, ".countEmit"}, range_count, emitIdx);
                    if (emitIdx < expS.size()) begin
                        checkOutput($sformatf("%s.start%0d", tag, emitIdx), rng_start, expS[emitIdx]);
                        checkOutput($sformatf("%s.end%0d", tag, emitIdx), rng_end, expE[emitIdx]);
                    end else begin
                        checkOutput({tag, ".extraEmit"}, emitIdx, expS.size());
                    end
                end
                in_valid = (idx < stim.size()) && (readyMode == 0 || $urandom_range(0, 3) != 0);
                in_data  = (idx < stim.size()) ? stim[idx] : 8'h00;
                in_last  = (idx == stim.size() - 1);
                start    = ($urandom_range(0, 15) == 0);
                case (readyMode)
                    0: rng_ready = 1'b1;
                    1: rng_ready = ($urandom_range(0, 2) != 0);
                    default: begin
                        rng_ready = !(rng_valid && stall < 5);
                        if (rng_valid && !rng_ready) stall++;
                    end
                endcase
                if (in_valid && in_ready) begin
                    idx++;
                    lastEvt = cyc;
                end
                if (rng_valid && rng_ready) begin
                    emitIdx++;
                    lastEvt = cyc;
                end
                @(negedge clk);
                cyc++;
            end
        end
        start = 1'b0;
        in_valid = 1'b0;
        in_last = 1'b0;
        checkOutput({tag, ".err"}, err, expErr);
        checkOutput({tag, ".count"}, range_count, expS.size());
        checkOutput({tag, ".emits"}, emitIdx, expS.size());
        checkOutput({tag, ".consumed"}, idx, expConsumed);
        checkOutput({tag, ".inReadyDone"}, in_ready, 0);
        checkOutput({tag, ".validDone"}, rng_valid, 0);
        checkOutput({tag, ".doneLatency"}, cyc, lastEvt + 1);
    endtask

    task automatic genRandom();
        logic [7:0] junk[6];
        int n, pos;
        junk = '{8'h78, 8'h20, 8'h2D, 8'h0A, 8'h0D, 8'h37};
        stim.delete();
        n = $urandom_range(1, 6);
        for (int i = 0; i < n; i++) addRange(randVal(), randVal(), $urandom_range(0, 5) == 0);
        if ($urandom_range(0, 3) != 0) begin
            if ($urandom_range(0, 4) == 0) stim.push_back(8'h0D);
            stim.push_back(8'h0A);
        end
        if ($urandom_range(0, 2) == 0) begin
            pos = $urandom_range(0, stim.size() - 1);
            stim[pos] = junk[$urandom_range(0, 5)];
        end
    endtask

    // Top-level sequence: reset, directed cases, limit case, random streams, mid-parse reset
    initial begin
        int idx;
        @(negedge clk);
        checkOutput("rst.inReady", in_ready, 0);
        checkOutput("rst.rngValid", rng_valid, 0);
        checkOutput("rst.rngStart", rng_start, 0);
        checkOutput("rst.rngEnd", rng_end, 0);
        checkOutput("rst.count", range_count, 0);
        checkOutput("rst.done", done, 0);
        checkOutput("rst.err", err, 0);
        rst = 1'b0;

        stim.delete(); addText("3-5\n10-14\n\n");
        applyStimulus("basic", 0);
        stim.delete(); addText("3-5\n10-14\n\n");
        applyStimulus("stall", 2);
        stim.delete(); addText("12-x\n");
        applyStimulus("badChar", 0);
        stim.delete(); addText("1125899906842624-1\n");
        applyStimulus("overflow", 1);
        stim.delete(); addText("1125899906842623-0\r\n\n");
        applyStimulus("maxVal", 1);
        stim.delete(); addText("9-4\n\n");
        applyStimulus("inverted", 0);

        stim.delete();
        for (int i = 0; i < MAXR + 8; i++) addRange(randVal() % 64'd1000000, randVal() % 64'd1000000, 1'b0);
        applyStimulus("maxRanges", 1);

        for (int t = 0; t < 30; t++) begin
            genRandom();
            applyStimulus($sformatf("rand%0d", t), 1);
        end

        stim.delete(); addText("7-8\n\n");
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        rng_ready = 1'b0;
        idx = 0;
        for (int k = 0; k < 20 && !rng_valid; k++) begin
            in_valid = (idx < stim.size());
            in_data  = (idx < stim.size()) ? stim[idx] : 8'h00;
            in_last  = 1'b0;
            if (in_valid && in_ready) idx++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        checkOutput("midRst.valid", rng_valid, 1);
        checkOutput("midRst.start", rng_start, 7);
        rst = 1'b1;
        #1;
        checkOutput("midRst.inReady", in_ready, 0);
        checkOutput("midRst.rngValid", rng_valid, 0);
        checkOutput("midRst.rngStart", rng_start, 0);
        checkOutput("midRst.rngEnd", rng_end, 0);
        checkOutput("midRst.count", range_count, 0);
        checkOutput("midRst.done", done, 0);
        checkOutput("midRst.err", err, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("postRst.done", done, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecCnt, errCnt);
        $finish;
    end

endmodule
